data_path: RTL and testbench

DATA_PATH -- requirements
Module: data_path

---
 rtl/data_path_if.sv | 35 +++
 rtl/data_path.sv | 109 ++++++++++
 tb/tb_data_path.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/data_path_if.sv
// data_path_if -- control, data and observation signals of the data_path block.
//   slave  : data_path side. Bus-source selects, register loads, Read,
//            IncPC, ALU op selects and Mdatain are inputs. BusMuxOut and
//            the *_q observation outputs are driven by the block.
//   master : controller/testbench side, with the same signals in the
//            opposite direction.
interface data_path_if;
  logic        PCout, Zlowout, Zhighout, MDRout, LOout, HIout;
  logic        R2out, R3out, R6out, R7out;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin;
  logic        R2in, R3in, R4in, R6in, R7in;
  logic        Read, IncPC;
  logic        AND, OR, ADD, SUB, MUL, DIV;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut;
  logic [31:0] IR_q, PC_q, MAR_q, R4_q, HI_q, LO_q;

  modport slave (
    input  PCout, Zlowout, Zhighout, MDRout, LOout, HIout,
           R2out, R3out, R6out, R7out,
           PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin,
           R2in, R3in, R4in, R6in, R7in,
           Read, IncPC, AND, OR, ADD, SUB, MUL, DIV, Mdatain,
    output BusMuxOut, IR_q, PC_q, MAR_q, R4_q, HI_q, LO_q
  );

  modport master (
    output PCout, Zlowout, Zhighout, MDRout, LOout, HIout,
           R2out, R3out, R6out, R7out,
           PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin,
           R2in, R3in, R4in, R6in, R7in,
           Read, IncPC, AND, OR, ADD, SUB, MUL, DIV, Mdatain,
    input  BusMuxOut, IR_q, PC_q, MAR_q, R4_q, HI_q, LO_q
  );
endinterface

// File: rtl/data_path.sv
// data_path -- 32-bit single-bus CPU datapath.
//   Registers R2, R3, R4, R6, R7, PC, IR, MAR, MDR, Y, HI and LO, plus a
//   64-bit Z (Zhigh:Zlow) that captures the ALU result.
//   Ports:
//     Clock  : all storage loads on its rising edge.
//     Resetn : asynchronous, active-low clear of every register.
//     dp     : data_path_if.slave, carrying the bus selects, load enables,
//              ALU op selects, Mdatain, BusMuxOut and the *_q outputs.
//   The ALU takes A = Y and B = BusMuxOut. It is combinational and is
//   captured into Z when Zin is set.
//   Build option: define DATAPATH_DIV_EN to build the signed divider.
//   Without it, DIV loads Z = 0.
module data_path (
  input  logic         Clock,
  input  logic         Resetn,
  data_path_if.slave   dp
);

  logic [31:0] r2, r3, r4, r6, r7, pc, ir, mar, mdr, y, hi, lo;
  logic [63:0] z;
  logic [31:0] bus;
  logic [63:0] alu;
  logic [63:0] product;
  logic signed [63:0] a_ext, b_ext;

  // Bus source mux. Earlier branches take priority. The bus is 0 when
  // no source is selected.
  always_comb begin
    bus = '0;
    if      (dp.MDRout)   bus = mdr;
    else if (dp.PCout)    bus = pc;
    else if (dp.Zlowout)  bus = z[31:0];
    else if (dp.Zhighout) bus = z[63:32];
    else if (dp.HIout)    bus = hi;
    else if (dp.LOout)    bus = lo;
    else if (dp.R2out)    bus = r2;
    else if (dp.R3out)    bus = r3;
    else if (dp.R6out)    bus = r6;
    else if (dp.R7out)    bus = r7;
  end

  assign a_ext   = {{32{y[31]}}, y};
  assign b_ext   = {{32{bus[31]}}, bus};
  assign product = a_ext * b_ext;

`ifdef DATAPATH_DIV_EN
  logic [63:0] div_res;

  // Signed divide. The quotient truncates toward zero, and the remainder
  // takes the sign of A. Divide-by-zero and the one overflowing case are
  // handled explicitly so the result never relies on simulator behaviour
  // for those cases.
  always_comb begin
    div_res = '0;
    if (bus == '0)
      div_res = {y, 32'hFFFF_FFFF};
    else if (y == 32'h8000_0000 && bus == '1)
      div_res = {32'h0, 32'h8000_0000};
    else
      div_res = {32'($signed(y) % $signed(bus)), 32'($signed(y) / $signed(bus))};
  end
`endif

  always_comb begin
    alu = '0;
    if      (dp.IncPC) alu = {32'h0, bus + 32'd1};
    else if (dp.AND)   alu = {32'h0, y & bus};
    else if (dp.OR)    alu = {32'h0, y | bus};
    else if (dp.ADD)   alu = {32'h0, y + bus};
    else if (dp.SUB)   alu = {32'h0, y - bus};
    else if (dp.MUL)   alu = product;
`ifdef DATAPATH_DIV_EN
    else if (dp.DIV)   alu = div_res;
`endif
  end

  // Every load samples the pre-edge bus value. A register that drives the
  // bus and also loads from it therefore keeps its old value.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r2  <= '0; r3 <= '0; r4 <= '0; r6 <= '0; r7 <= '0;
      pc  <= '0; ir <= '0; mar <= '0; mdr <= '0; y <= '0;
      hi  <= '0; lo <= '0; z <= '0;
    end else begin
      if (dp.R2in)  r2  <= bus;
      if (dp.R3in)  r3  <= bus;
      if (dp.R4in)  r4  <= bus;
      if (dp.R6in)  r6  <= bus;
      if (dp.R7in)  r7  <= bus;
      if (dp.PCin)  pc  <= bus;
      if (dp.IRin)  ir  <= bus;
      if (dp.MARin) mar <= bus;
      if (dp.MDRin) mdr <= dp.Read ? dp.Mdatain : bus;
      if (dp.Yin)   y   <= bus;
      if (dp.HIin)  hi  <= bus;
      if (dp.LOin)  lo  <= bus;
      if (dp.Zin)   z   <= alu;
    end
  end

  assign dp.BusMuxOut = bus;
  assign dp.IR_q      = ir;
  assign dp.PC_q      = pc;
  assign dp.MAR_q     = mar;
  assign dp.R4_q      = r4;
  assign dp.HI_q      = hi;
  assign dp.LO_q      = lo;

endmodule

// File: tb/tb_data_path.sv
module tb_data_path;
  logic Clock;
  logic Resetn;
  int unsigned n_checks;
  int unsigned n_errors;

  data_path_if dif ();

  data_path u_dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .dp     (dif.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_ctl();
    dif.PCout = 0; dif.Zlowout = 0; dif.Zhighout = 0; dif.MDRout = 0;
    dif.LOout = 0; dif.HIout = 0; dif.R2out = 0; dif.R3out = 0;
    dif.R6out = 0; dif.R7out = 0;
    dif.PCin = 0; dif.IRin = 0; dif.MARin = 0; dif.MDRin = 0; dif.Yin = 0;
    dif.Zin = 0; dif.LOin = 0; dif.HIin = 0; dif.R2in = 0; dif.R3in = 0;
    dif.R4in = 0; dif.R6in = 0; dif.R7in = 0;
    dif.Read = 0; dif.IncPC = 0;
    dif.AND = 0; dif.OR = 0; dif.ADD = 0; dif.SUB = 0; dif.MUL = 0; dif.DIV = 0;
  endtask

  // Apply one clock edge, then drop all controls.
  task automatic tick();
    @(posedge Clock);
    #1;
    clear_ctl();
    #1;
  endtask

  // Put a constant into MDR from memory.
  task automatic mem_to_mdr(input logic [31:0] v);
    dif.Mdatain = v; dif.Read = 1; dif.MDRin = 1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_ctl();
    dif.Mdatain = '0;
    Resetn = 1'b1;
    #2 Resetn = 1'b0;
    #1;
    // The clear is asynchronous: no clock edge has occurred yet.
    check("rst_bus", dif.BusMuxOut, 32'h0);
    check("rst_pc",  dif.PC_q,  32'h0);
    check("rst_ir",  dif.IR_q,  32'h0);
    check("rst_mar", dif.MAR_q, 32'h0);
    check("rst_r4",  dif.R4_q,  32'h0);
    check("rst_hilo", dif.HI_q | dif.LO_q, 32'h0);
    @(negedge Clock);
    Resetn = 1'b1;
    #1;

    // Load R3 from memory through MDR.
    mem_to_mdr(32'h22);
    dif.MDRout = 1; dif.R3in = 1;
    #1 check("mdr_bus", dif.BusMuxOut, 32'h22);
    tick();
    dif.R3out = 1;
    #1 check("r3_val", dif.BusMuxOut, 32'h22);
    clear_ctl();

    mem_to_mdr(32'h24);
    dif.MDRout = 1; dif.R7in = 1; tick();

    // Bus priority: MDR wins over R3. No selected source gives 0.
    dif.MDRout = 1; dif.R3out = 1; dif.PCout = 1;
    #1 check("prio_mdr", dif.BusMuxOut, 32'h24);
    clear_ctl();
    #1 check("bus_idle", dif.BusMuxOut, 32'h0);

    // ADD, SUB, AND and OR with Y = R3 = 0x22 and B = R7 = 0x24.
    dif.R3out = 1; dif.Yin = 1; tick();
    dif.R7out = 1; dif.ADD = 1; dif.Zin = 1; tick();
    dif.Zlowout = 1; dif.R4in = 1; tick();
    check("add_r4", dif.R4_q, 32'h46);
    dif.Zhighout = 1;
    #1 check("add_zhi", dif.BusMuxOut, 32'h0);
    clear_ctl();
    dif.R7out = 1; dif.SUB = 1; dif.Zin = 1; tick();
    dif.Zlowout = 1; dif.R4in = 1; tick();
    check("sub_r4", dif.R4_q, 32'hFFFF_FFFE);
    dif.R7out = 1; dif.AND = 1; dif.Zin = 1; tick();
    dif.Zlowout = 1;
    #1 check("and_z", dif.BusMuxOut, 32'h20);
    clear_ctl();
    dif.R7out = 1; dif.OR = 1; dif.Zin = 1; tick();
    dif.Zlowout = 1;
    #1 check("or_z", dif.BusMuxOut, 32'h26);
    clear_ctl();

    // Instruction fetch starting from PC = 0.
    dif.PCout = 1; dif.MARin = 1; dif.IncPC = 1; dif.Zin = 1; tick();
    check("fetch_mar", dif.MAR_q, 32'h0);
    dif.Zlowout = 1;
    #1 check("fetch_zlow", dif.BusMuxOut, 32'h1);
    dif.PCin = 1; dif.Read = 1; dif.MDRin = 1; dif.Mdatain = 32'h1A2B_8000;
    tick();
    check("fetch_pc", dif.PC_q, 32'h1);
    dif.MDRout = 1; dif.IRin = 1; tick();
    check("fetch_ir", dif.IR_q, 32'h1A2B_8000);

    // PC drives the bus and loads from it on the same edge, so PC keeps
    // its old value. MAR, loaded on the same edge, gets that same value.
    dif.PCout = 1; dif.PCin = 1; dif.MARin = 1; tick();
    check("rw_pc",  dif.PC_q,  32'h1);
    check("rw_mar", dif.MAR_q, 32'h1);

    // MUL: -2 * 3 = -6.
    mem_to_mdr(32'hFFFF_FFFE);
    dif.MDRout = 1; dif.R2in = 1; tick();
    mem_to_mdr(32'h3);
    dif.MDRout = 1; dif.R6in = 1; tick();
    dif.R2out = 1; dif.Yin = 1; tick();
    dif.R6out = 1; dif.MUL = 1; dif.Zin = 1; tick();
    dif.Zlowout = 1; dif.LOin = 1; tick();
    dif.Zhighout = 1; dif.HIin = 1; tick();
    check("mul_lo", dif.LO_q, 32'hFFFF_FFFA);
    check("mul_hi", dif.HI_q, 32'hFFFF_FFFF);

    // Op priority: ADD beats MUL. Y = -2 and B = 3 give 1, with Zhigh = 0.
    dif.R6out = 1; dif.ADD = 1; dif.MUL = 1; dif.Zin = 1; tick();
    dif.Zlowout = 1;
    #1 check("prio_add_lo", dif.BusMuxOut, 32'h1);
    clear_ctl(); dif.Zhighout = 1;
    #1 check("prio_add_hi", dif.BusMuxOut, 32'h0);
    clear_ctl();

    // Zin with no op selected loads Z = 0.
    dif.R6out = 1; dif.Zin = 1; tick();
    dif.Zlowout = 1;
    #1 check("noop_z", dif.BusMuxOut, 32'h0);
    clear_ctl();

    // DIV: 7 / -2 and 7 / 0.
    mem_to_mdr(32'h7);
    dif.MDRout = 1; dif.Yin = 1; tick();
    mem_to_mdr(32'hFFFF_FFFE);
    dif.MDRout = 1; dif.DIV = 1; dif.Zin = 1; tick();
    dif.Zlowout = 1;
`ifdef DATAPATH_DIV_EN
    #1 check("div_q", dif.BusMuxOut, 32'hFFFF_FFFD);
`else
    #1 check("div_q", dif.BusMuxOut, 32'h0);
`endif
    clear_ctl(); dif.Zhighout = 1;
`ifdef DATAPATH_DIV_EN
    #1 check("div_r", dif.BusMuxOut, 32'h1);
`else
    #1 check("div_r", dif.BusMuxOut, 32'h0);
`endif
    clear_ctl();
    dif.DIV = 1; dif.Zin = 1; tick();
    dif.Zlowout = 1;
`ifdef DATAPATH_DIV_EN
    #1 check("div0_q", dif.BusMuxOut, 32'hFFFF_FFFF);
`else
    #1 check("div0_q", dif.BusMuxOut, 32'h0);
`endif
    clear_ctl(); dif.Zhighout = 1;
`ifdef DATAPATH_DIV_EN
    #1 check("div0_r", dif.BusMuxOut, 32'h7);
`else
    #1 check("div0_r", dif.BusMuxOut, 32'h0);
`endif
    clear_ctl();

    // Reset between the MUL step and the LO write-back aborts the sequence.
    dif.R2out = 1; dif.Yin = 1; tick();
    dif.R6out = 1; dif.MUL = 1; dif.Zin = 1; tick();
    dif.Zlowout = 1; dif.LOin = 1;
    Resetn = 1'b0;
    #1;
    check("abort_lo",  dif.LO_q, 32'h0);
    check("abort_hi",  dif.HI_q, 32'h0);
    check("abort_pc",  dif.PC_q, 32'h0);
    check("abort_bus", dif.BusMuxOut, 32'h0);
    @(negedge Clock);
    Resetn = 1'b1;
    tick();
    check("resume_lo", dif.LO_q, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
